avmem_slave: RTL
================

# avmem_slave

Avalon-MM slave memory sitting directly downstream of `top_level_cpu`, servicing its instruction fetches and data loads/stores. Word-organised storage with a configurable wait-state sequencer driving `waitrequest`, byte-lane writes, and a synchronous preload port used by benches to place program words before the CPU leaves reset.

## Interface
- `ADDR_W`, 8: log2 of word count; storage is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 1: cycles `waitrequest` is held high per transfer; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; the CPU-side active-high reset is inverted at integration.
- `address`  in  32  byte address from CPU; word index = `address[ADDR_W+1:2]`; `[1:0]` and bits above `ADDR_W+1` ignored (aliasing).
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  store data, lane i = bits [8i+7:8i].
- `byteenable`  in  4  per-lane write enable.
- `waitrequest`  out  1  slave stall.
- `readdata`  out  32  read data, valid when `read` high and `waitrequest` low.
- `inst_input`  in  1  preload enable.
- `inst_addr`  in  8  preload byte address; word index = `inst_addr[ADDR_W+1:2]` (zero-extended if ADDR_W > 6).
- `instruction`  in  32  preload word.

## Operation
- FSM states IDLE, WAIT; 4-bit counter `cnt`.
- IDLE: on `read|write` and `inst_input` low -> WAIT, `cnt <= WAIT_CYCLES-1`.
- WAIT, `cnt != 0`: decrement, stay.
- WAIT, `cnt == 0`: acknowledge cycle; write commits at end of it; -> IDLE.
- WAIT, request dropped (protocol violation): -> IDLE, no write.
- `waitrequest` (combinational) = `inst_input` | (IDLE & (`read|write`)) | (WAIT & `cnt != 0`).
- `readdata` register: loaded with `mem[idx]` on every edge where `read` high; holds otherwise.
- Write merge: lane i updated iff `byteenable[i]`; `byteenable == 0` completes handshake, no change.
- `read` and `write` both high: treated as write; `readdata` still loads pre-write word.
- Preload: each edge with `inst_input` high writes `instruction` to `mem[inst_addr idx]`, full word; bus requests stalled for that duration; preload takes priority over a same-edge bus write.
- Storage not cleared by reset; simulation power-up contents all zero.

## Timing
- Reset asserted: state IDLE, `cnt` 0, `readdata` 32'h0, pending write discarded; `waitrequest` follows its equation (high if a request is present).
- Request first sampled in cycle T: `waitrequest` high T..T+WAIT_CYCLES-1, low at T+WAIT_CYCLES; transfer completes at end of that cycle.
- Back-to-back: next request seen in IDLE at T+WAIT_CYCLES+1; throughput one transfer per WAIT_CYCLES+1 cycles.
- Read-after-write to same word: second transfer returns new data (write commits before its WAIT states load `readdata`).
- Reset release mid-stream: first edge after release treats any asserted request as new.

## Configuration
- `AVMEM_BYTEENABLE_EN` defined: per-lane merge as above.
- Undefined: `byteenable` ignored, every bus write is full-word; port retained for interface compatibility.

## Structure
- Package `avmem_pkg`: state enum typedef (IDLE, WAIT), `WORD_W = 32`, `CNT_W = 4`, lane-merge function.
- Sub-module `avmem_array`: 2^ADDR_W x 32 storage, one prioritised write port (preload over bus) and one read port; FSM, counter, and `readdata` register stay in the top.

## Test plan
- Preload 0x04 = 32'h24030FF0, 0x08 = 32'h386200FF, reset released; read 0x04 with WAIT_CYCLES=1 -> `waitrequest` high 1 cycle then low, `readdata` = 32'h24030FF0.
- Write 32'hDEADBEEF to 0x10, byteenable 4'b0101, word previously 32'h11223344 -> subsequent read 0x10 = 32'h11AD33EF (macro on) / 32'hDEADBEEF (macro off).
- WAIT_CYCLES=3, reads 0x04 and 0x08 back-to-back -> `waitrequest` pattern H,H,H,L,H,H,H,L; data 32'h24030FF0 then 32'h386200FF.
- Read 0x404 with ADDR_W=8 -> aliases to 0x04, returns 32'h24030FF0; read 0x07 returns same word.
- Reset asserted during WAIT of a write of 32'hCAFEF00D to 0x20 -> word at 0x20 unchanged, `readdata` = 0, state IDLE.
- `inst_input` held high while CPU asserts `read` -> `waitrequest` high throughout; read completes WAIT_CYCLES+1 cycles after `inst_input` falls.

Source files
------------

// File: rtl/avmem_pkg.sv
// Shared types and helpers for the Avalon-MM slave memory.
// The lane-merge function applies a byte-enable mask to a stored word.
package avmem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [3:0]        be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/avmem_array.sv
// Word storage for avmem_slave: one write port shared by preload and bus
// (preload wins), one asynchronous read port. Contents survive reset.
module avmem_array
    import avmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              pre_we,
    input  logic [ADDR_W-1:0] pre_idx,
    input  logic [WORD_W-1:0] pre_data,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_idx,
    input  logic [WORD_W-1:0] bus_data,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [WORD_W-1:0] wr_data;

    always_comb begin
        wr_en   = pre_we | bus_we;
        wr_idx  = bus_idx;
        wr_data = bus_data;
        if (pre_we) begin
            wr_idx  = pre_idx;
            wr_data = pre_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/avmem_slave.sv
// Avalon-MM slave memory with a WAIT_CYCLES wait-state sequencer and a preload port.
// Define AVMEM_BYTEENABLE_EN for per-lane writes; otherwise every bus write is full-word.
module avmem_slave
    import avmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic              waitrequest,
    output logic [31:0]       readdata,
    input  logic              inst_input,
    input  logic [7:0]        inst_addr,
    input  logic [31:0]       instruction
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] readdata_q, readdata_d;
    logic              req;
    logic              ack;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_idx;
    logic [ADDR_W-1:0] pre_idx;
    logic [31:0]       inst_addr_ext;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] bus_wdata;
    logic              unused_bits;

    assign req           = read | write;
    assign bus_idx       = address[ADDR_W+1:2];
    assign inst_addr_ext = {24'h0, inst_addr};
    assign pre_idx       = inst_addr_ext[ADDR_W+1:2];
    assign unused_bits   = ^{address[31:ADDR_W+2], address[1:0],
                             inst_addr_ext[31:ADDR_W+2], inst_addr_ext[1:0]};

    // A pending transfer is frozen while preload owns the array.
    assign ack    = (state_q == WAIT) && (cnt_q == '0) && req && !inst_input;
    assign bus_we = ack && write;

    assign waitrequest = inst_input
                       | ((state_q == IDLE) & req)
                       | ((state_q == WAIT) & (cnt_q != '0));

`ifdef AVMEM_BYTEENABLE_EN
    assign bus_wdata = lane_merge(rd_word, writedata, byteenable);
`else
    logic unused_be;
    assign unused_be = ^byteenable;
    assign bus_wdata = writedata;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req && !inst_input) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            default: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!inst_input) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    assign readdata_d = read ? rd_word : readdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

    avmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .pre_we   (inst_input),
        .pre_idx  (pre_idx),
        .pre_data (instruction),
        .bus_we   (bus_we),
        .bus_idx  (bus_idx),
        .bus_data (bus_wdata),
        .rd_idx   (bus_idx),
        .rd_data  (rd_word)
    );

endmodule
